// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator.
// Compares two N-bit operands W bits per cycle, starting with the most significant
// chunk, and stops at the first chunk that differs. A signed compare is turned into
// an unsigned one by inverting the top bit of both operands when they are captured.
// The result (eq/lt/gt plus the number of chunks examined) is held until the consumer
// takes it.
module comparator_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [N-1:0]                a,
    input  logic [N-1:0]                b,
    input  logic                        is_signed,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic                        eq,
    output logic                        lt,
    output logic                        gt,
    output logic [$clog2(N/W+1)-1:0]    o_chunks
);

    localparam int C  = N / W;
    localparam int CW = $clog2(C + 1);
    // The index is kept at least one bit wide so that W == N still elaborates cleanly.
    localparam int IW = (C > 1) ? $clog2(C) : 1;
    // The chunk table is padded to a power of two so every index value selects a real entry.
    localparam int CP = 1 << IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(C - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_sign_flip;
    logic [W-1:0]    w_a_chunk [CP];
    logic [W-1:0]    w_b_chunk [CP];
    logic [W-1:0]    w_a_sel;
    logic [W-1:0]    w_b_sel;
    logic [CW-1:0]   w_cnt_next;

    // Only the top bit is flipped in signed mode; this maps two's-complement order onto unsigned order.
    always_comb begin
        w_sign_flip        = '0;
        w_sign_flip[N-1]   = is_signed;
    end

    // Slice the captured operands into chunks; padding entries read as zero and are never selected.
    for (genvar gi = 0; gi < CP; gi++) begin : g_chunk
        if (gi < C) begin : g_real
            assign w_a_chunk[gi] = r_a[gi*W +: W];
            assign w_b_chunk[gi] = r_b[gi*W +: W];
        end else begin : g_pad
            assign w_a_chunk[gi] = '0;
            assign w_b_chunk[gi] = '0;
        end
    end

    assign w_a_sel    = w_a_chunk[r_idx];
    assign w_b_sel    = w_b_chunk[r_idx];
    assign w_cnt_next = r_cnt + 1'b1;
    assign i_ready    = r_ready;

    // Control FSM: capture in IDLE, one chunk per cycle in COMPARE, hold the result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= LAST_IDX;
            r_cnt    <= '0;
            o_valid  <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            gt       <= 1'b0;
            o_chunks <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && r_ready) begin
                        r_a     <= a ^ w_sign_flip;
                        r_b     <= b ^ w_sign_flip;
                        r_idx   <= LAST_IDX;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    r_cnt <= w_cnt_next;
                    if (w_a_sel != w_b_sel) begin
                        // First differing chunk decides the ordering.
                        lt       <= (w_a_sel < w_b_sel);
                        gt       <= !(w_a_sel < w_b_sel);
                        eq       <= 1'b0;
                        o_chunks <= w_cnt_next;
                        o_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_idx == '0) begin
                        // Every chunk matched.
                        eq       <= 1'b1;
                        lt       <= 1'b0;
                        gt       <= 1'b0;
                        o_chunks <= w_cnt_next;
                        o_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (o_ready) begin
                        o_valid  <= 1'b0;
                        eq       <= 1'b0;
                        lt       <= 1'b0;
                        gt       <= 1'b0;
                        o_chunks <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq at W = 1, 8 and 32 (N = 32). Each instance has a driver
// that pushes expected results into a queue and a monitor that pops and compares
// whenever the DUT presents o_valid. Expectations come from plain integer compares.
`timescale 1ns/1ps
module tb_comparator_seq;

    localparam int N     = 32;
    localparam int NDIR  = 7;
    localparam int NRAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;

    typedef struct {
        logic e;
        logic l;
        logic g;
        int   k;
        int   acc;
        int   stall;
    } exp_t;

    logic [31:0] dir_a [NDIR] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd38273, 32'd8,
                                  32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFF8};
    logic [31:0] dir_b [NDIR] = '{32'h00000001, 32'h00000001, 32'd38273, 32'd9,
                                  32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF7};
    logic        dir_s [NDIR] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic chk(input int w, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL W%0d %s: got %0h expected %0h (t=%0t)", w, name, act, req, $time);
        end
    endtask

    // Reference: integer compare for the ordering, chunk count from the leading equal chunks.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic s,
                                  input int w, output logic e, output logic l, output logic g,
                                  output int k);
        int          c;
        logic [63:0] mask;
        logic [63:0] xa;
        logic [63:0] xb;
        c    = 32 / w;
        mask = (64'd1 << w) - 64'd1;
        xa   = {32'd0, ma};
        xb   = {32'd0, mb};
        e    = (ma == mb);
        l    = s ? ($signed(ma) < $signed(mb)) : (ma < mb);
        g    = !e && !l;
        k    = c;
        for (int i = c - 1; i >= 0; i--) begin
            if (((xa >> (i * w)) & mask) != ((xb >> (i * w)) & mask)) begin
                k = c - i;
                break;
            end
        end
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int W  = (gi == 0) ? 1 : ((gi == 1) ? 8 : 32);
        localparam int C  = N / W;
        localparam int CW = $clog2(C + 1);

        logic          rst;
        logic          i_valid;
        logic          i_ready;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic          is_signed;
        logic          o_valid;
        logic          o_ready;
        logic          eq;
        logic          lt;
        logic          gt;
        logic [CW-1:0] o_chunks;

        exp_t q[$];

        comparator_seq #(.N(N), .W(W)) dut (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (i_valid),
            .i_ready   (i_ready),
            .a         (a),
            .b         (b),
            .is_signed (is_signed),
            .o_valid   (o_valid),
            .o_ready   (o_ready),
            .eq        (eq),
            .lt        (lt),
            .gt        (gt),
            .o_chunks  (o_chunks)
        );

        // Driver: reset checks, reset during COMPARE, then directed and random transactions.
        initial begin
            exp_t        e;
            logic [31:0] ta;
            logic [31:0] tb_v;
            logic        ts;
            int          wt;
            bit          timeout;
            rst       = 1'b1;
            i_valid   = 1'b0;
            a         = '0;
            b         = '0;
            is_signed = 1'b0;
            timeout   = 1'b0;
            repeat (3) @(negedge clk);
            chk(W, "reset i_ready", i_ready, 1);
            chk(W, "reset o_valid", o_valid, 0);
            chk(W, "reset eq/lt/gt", {eq, lt, gt}, 0);
            chk(W, "reset o_chunks", o_chunks, 0);
            rst = 1'b0;

            // Accept a transaction, then reset while it is being compared.
            i_valid   = 1'b1;
            a         = 32'h1234_5678;
            b         = 32'h1234_5678;
            is_signed = 1'b1;
            @(negedge clk);
            i_valid = 1'b0;
            rst     = 1'b1;
            chk(W, "busy after accept", i_ready, 0);
            @(negedge clk);
            rst = 1'b0;
            chk(W, "idle after mid-compare reset", i_ready, 1);
            chk(W, "no o_valid after reset", o_valid, 0);
            repeat (C + 2) begin
                @(negedge clk);
                chk(W, "discarded result stays silent", o_valid, 0);
            end

            for (int t = 0; t < NDIR + NRAND && !timeout; t++) begin
                if (t < NDIR) begin
                    ta      = dir_a[t];
                    tb_v    = dir_b[t];
                    ts      = dir_s[t];
                    e.stall = 3;
                end else begin
                    ta = $urandom;
                    case ($urandom_range(3))
                        0:       tb_v = ta;
                        1:       tb_v = ta ^ (32'h1 << $urandom_range(31));
                        default: tb_v = $urandom;
                    endcase
                    ts      = 1'($urandom_range(1));
                    e.stall = $urandom_range(3);
                end
                // While busy, wiggle the inputs; none of this may be accepted.
                wt = 0;
                while (!i_ready && !timeout) begin
                    i_valid   = 1'($urandom_range(1));
                    a         = $urandom;
                    b         = $urandom;
                    is_signed = 1'($urandom_range(1));
                    @(negedge clk);
                    wt++;
                    if (wt > 200) begin
                        chk(W, "i_ready within bound", i_ready, 1);
                        timeout = 1'b1;
                    end
                end
                if (!timeout) begin
                    i_valid   = 1'b1;
                    a         = ta;
                    b         = tb_v;
                    is_signed = ts;
                    model(ta, tb_v, ts, W, e.e, e.l, e.g, e.k);
                    e.acc = cyc + 1;
                    q.push_back(e);
                    @(negedge clk);
                    chk(W, "i_ready low after accept", i_ready, 0);
                    i_valid   = 1'($urandom_range(1));
                    a         = $urandom;
                    b         = $urandom;
                    is_signed = 1'($urandom_range(1));
                end
            end

            i_valid = 1'b0;
            wt = 0;
            while (!i_ready && wt <= 200) begin
                @(negedge clk);
                wt++;
            end
            chk(W, "final idle", i_ready, 1);
            chk(W, "scoreboard drained", q.size(), 0);
            done_cnt++;
        end

        // Monitor: pop and compare on each new result, check hold under stall and clear after handshake.
        initial begin
            exp_t cur;
            bit   in_res;
            int   rem;
            in_res  = 1'b0;
            rem     = 0;
            o_ready = 1'b0;
            forever begin
                @(negedge clk);
                if (in_res && o_ready) begin
                    chk(W, "o_valid cleared", o_valid, 0);
                    chk(W, "flags cleared", {eq, lt, gt}, 0);
                    chk(W, "o_chunks cleared", o_chunks, 0);
                    chk(W, "i_ready after handshake", i_ready, 1);
                    in_res  = 1'b0;
                    o_ready = 1'b0;
                end else if (o_valid) begin
                    chk(W, "i_ready low while done", i_ready, 0);
                    if (!in_res) begin
                        chk(W, "result expected", (q.size() > 0), 1);
                        if (q.size() > 0) begin
                            cur = q.pop_front();
                            chk(W, "eq", eq, cur.e);
                            chk(W, "lt", lt, cur.l);
                            chk(W, "gt", gt, cur.g);
                            chk(W, "o_chunks", o_chunks, cur.k);
                            chk(W, "latency", cyc - cur.acc, cur.k);
                            in_res = 1'b1;
                            rem    = cur.stall;
                        end
                    end else begin
                        chk(W, "held flags", {eq, lt, gt}, {cur.e, cur.l, cur.g});
                        chk(W, "held o_chunks", o_chunks, cur.k);
                        rem--;
                    end
                    o_ready = in_res && (rem <= 0);
                end else if (in_res) begin
                    chk(W, "o_valid held under stall", o_valid, 1);
                    in_res  = 1'b0;
                    o_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        while (done_cnt < 3 && cyc < 95000) @(negedge clk);
        chk(0, "all drivers finished", done_cnt, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
